dose_dispense_scheduler: RTL and testbench

- Schedules and sequences the medication box around a single shared mechanical dispenser.
- Keeps hour-of-day and a programmable dose hour per compartment.
- Raises per-compartment dispense requests at the scheduled hour and arbitrates them round-robin onto one dispenser req/ack handshake.
- After dispensing, holds a patient alarm until the patient presses the taken button, or until it times out as a missed dose.

---
 rtl/dose_dispense_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_dose_dispense_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dose_dispense_scheduler.sv
// Medication box scheduler: hour clock, per-slot dose hours, round-robin dispenser grant, patient alarm/missed tracking.
// Latency: hour_tick at cycle t raises disp_req at t+2; grants are separated by one GAP plus one IDLE cycle.
// Backpressure: disp_req/disp_slot hold until disp_ack or a DISP_TIMEOUT-cycle abandon; the abandoned slot stays pending.
module dose_dispense_scheduler #(
  parameter int DAY_HOURS    = 24,
  parameter int ALARM_HOURS  = 3,
  parameter int DISP_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hour_tick,
  input  logic       cfg_we,
  input  logic [1:0] cfg_slot,
  input  logic [4:0] cfg_hour,
  input  logic       cfg_en,
  input  logic [3:0] taken,
  input  logic       disp_ack,
  output logic [4:0] hour_now,
  output logic       disp_req,
  output logic [1:0] disp_slot,
  output logic [3:0] alarm,
  output logic [3:0] missed
);

  localparam int N_SLOTS = 4;
  localparam int AW      = $clog2(ALARM_HOURS + 1);
  localparam int TW      = $clog2(DISP_TIMEOUT);

  localparam logic [AW-1:0] AGE_LAST  = AW'(ALARM_HOURS);
  localparam logic [TW-1:0] TMO_LAST  = TW'(DISP_TIMEOUT - 1);
  localparam logic [4:0]    HOUR_LAST = 5'(DAY_HOURS - 1);
  localparam logic [4:0]    HOUR_LIM  = 5'(DAY_HOURS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  state_t                 state_q, state_d;
  logic [4:0]             hour_q, hour_d;
  logic [1:0]             disp_slot_q, disp_slot_d;
  logic [1:0]             rr_q, rr_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [N_SLOTS-1:0]     pending_q, pending_d;
  logic [N_SLOTS-1:0]     alarm_q, alarm_d;
  logic [N_SLOTS-1:0]     missed_q, missed_d;
  logic [N_SLOTS-1:0]     en_q, en_d;
  logic [4:0]             sched_q [N_SLOTS];
  logic [4:0]             sched_d [N_SLOTS];
  logic [AW-1:0]          age_q [N_SLOTS];
  logic [AW-1:0]          age_d [N_SLOTS];

  logic                   cfg_ok;
  logic                   ack_fire;
  logic                   pick_vld;
  logic [1:0]             pick_slot;

  // Hour counter and config-write qualification (out-of-range hours drop the whole write)
  always_comb begin
    hour_d = hour_q;
    if (hour_tick) begin
      hour_d = (hour_q == HOUR_LAST) ? 5'd0 : hour_q + 5'd1;
    end
    cfg_ok = cfg_we && (cfg_hour < HOUR_LIM);
  end

  // Dispenser FSM: round-robin pick in IDLE, hold in REQ until ack or timeout, one GAP cycle
  always_comb begin
    state_d     = state_q;
    disp_slot_d = disp_slot_q;
    rr_d        = rr_q;
    tmo_d       = tmo_q;
    ack_fire    = 1'b0;
    pick_vld    = 1'b0;
    pick_slot   = rr_q;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (!pick_vld && pending_q[rr_q + 2'(k)]) begin
        pick_vld  = 1'b1;
        pick_slot = rr_q + 2'(k);
      end
    end
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          disp_slot_d = pick_slot;
          tmo_d       = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (disp_ack) begin
          ack_fire = 1'b1;
          rr_d     = disp_slot_q + 2'd1;
          state_d  = S_GAP;
        end else if (tmo_q == TMO_LAST) begin
          rr_d    = disp_slot_q + 2'd1;
          state_d = S_GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-slot schedule, hit detection, pending set/clear, alarm aging and taken handling
  always_comb begin
    pending_d = pending_q;
    alarm_d   = alarm_q;
    missed_d  = '0;
    en_d      = en_q;
    sched_d   = sched_q;
    age_d     = age_q;
    for (int i = 0; i < N_SLOTS; i++) begin
      // A slot is "covered" only while its grant is live in REQ
      if (cfg_ok && (cfg_slot == 2'(i))) begin
        sched_d[i] = cfg_hour;
        en_d[i]    = cfg_en;
        if (!((state_q == S_REQ) && (disp_slot_q == 2'(i)))) begin
          pending_d[i] = 1'b0;
        end
      end
      if (hour_tick && en_q[i] && (hour_d == sched_q[i]) &&
          !pending_q[i] && !alarm_q[i] &&
          !((state_q == S_REQ) && (disp_slot_q == 2'(i))) &&
          !(cfg_ok && (cfg_slot == 2'(i)))) begin
        pending_d[i] = 1'b1;
      end
      // Taken beats a same-cycle expiry, so no missed pulse in that case
      if (alarm_q[i]) begin
        if (taken[i]) begin
          alarm_d[i] = 1'b0;
          age_d[i]   = '0;
        end else if (hour_tick) begin
          if ((age_q[i] + AW'(1)) == AGE_LAST) begin
            alarm_d[i]  = 1'b0;
            missed_d[i] = 1'b1;
            age_d[i]    = '0;
          end else begin
            age_d[i] = age_q[i] + AW'(1);
          end
        end
      end
      if (ack_fire && (disp_slot_q == 2'(i))) begin
        pending_d[i] = 1'b0;
        alarm_d[i]   = 1'b1;
        age_d[i]     = '0;
      end
    end
  end

  // State registers with synchronous reset to the default schedule 3/6/2/5, all enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hour_q      <= '0;
      disp_slot_q <= '0;
      rr_q        <= '0;
      tmo_q       <= '0;
      pending_q   <= '0;
      alarm_q     <= '0;
      missed_q    <= '0;
      en_q        <= '1;
      sched_q[0]  <= 5'd3;
      sched_q[1]  <= 5'd6;
      sched_q[2]  <= 5'd2;
      sched_q[3]  <= 5'd5;
      age_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      disp_slot_q <= disp_slot_d;
      rr_q        <= rr_d;
      tmo_q       <= tmo_d;
      pending_q   <= pending_d;
      alarm_q     <= alarm_d;
      missed_q    <= missed_d;
      en_q        <= en_d;
      sched_q     <= sched_d;
      age_q       <= age_d;
    end
  end

  assign hour_now  = hour_q;
  assign disp_req  = (state_q == S_REQ);
  assign disp_slot = disp_slot_q;
  assign alarm     = alarm_q;
  assign missed    = missed_q;

endmodule

// File: tb/tb_dose_dispense_scheduler.sv
// Bench for dose_dispense_scheduler: vector table for the normal schedule/grant/alarm flow,
// hand sequences for dispenser timeout, reset during a grant, and the 24-hour wrap.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_dose_dispense_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hour_tick = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_slot = 2'd0;
  logic [4:0] cfg_hour = 5'd0;
  logic       cfg_en = 1'b0;
  logic [3:0] taken = 4'd0;
  logic       disp_ack = 1'b0;
  logic [4:0] hour_now;
  logic       disp_req;
  logic [1:0] disp_slot;
  logic [3:0] alarm;
  logic [3:0] missed;

  int total = 0;
  int bad   = 0;
  int sched_ref [4] = '{3, 6, 2, 5};

  typedef struct {
    logic       tick;
    logic       we;
    logic [1:0] cslot;
    logic [4:0] chour;
    logic       cen;
    logic [3:0] tk;
    logic       ack;
    logic [4:0] e_hour;
    logic       e_req;
    logic [1:0] e_slot;
    logic [3:0] e_alarm;
    logic [3:0] e_missed;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  dose_dispense_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .hour_tick (hour_tick),
    .cfg_we    (cfg_we),
    .cfg_slot  (cfg_slot),
    .cfg_hour  (cfg_hour),
    .cfg_en    (cfg_en),
    .taken     (taken),
    .disp_ack  (disp_ack),
    .hour_now  (hour_now),
    .disp_req  (disp_req),
    .disp_slot (disp_slot),
    .alarm     (alarm),
    .missed    (missed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_cfg(input logic [1:0] s, input logic [4:0] h, input logic e);
    cfg_we   = 1'b1;
    cfg_slot = s;
    cfg_hour = h;
    cfg_en   = e;
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    //            tick we  slot  hour  en   taken    ack   hour  req  slot  alarm    missed
    vecs[0]  = '{1'b0,1'b1,2'd2,5'd4,1'b1,4'b0000,1'b0, 5'd0,1'b0,2'd0,4'b0000,4'b0000};
    vecs[1]  = '{1'b1,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b0, 5'd1,1'b0,2'd0,4'b0000,4'b0000};
    vecs[2]  = '{1'b1,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b0, 5'd2,1'b0,2'd0,4'b0000,4'b0000};
    vecs[3]  = '{1'b1,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b0, 5'd3,1'b0,2'd0,4'b0000,4'b0000};
    vecs[4]  = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b0, 5'd3,1'b1,2'd0,4'b0000,4'b0000};
    vecs[5]  = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b1, 5'd3,1'b0,2'd0,4'b0001,4'b0000};
    vecs[6]  = '{1'b0,1'b1,2'd1,5'd4,1'b1,4'b0000,1'b0, 5'd3,1'b0,2'd0,4'b0001,4'b0000};
    vecs[7]  = '{1'b1,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b0, 5'd4,1'b0,2'd0,4'b0001,4'b0000};
    vecs[8]  = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b0, 5'd4,1'b1,2'd1,4'b0001,4'b0000};
    vecs[9]  = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b1, 5'd4,1'b0,2'd1,4'b0011,4'b0000};
    vecs[10] = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b0, 5'd4,1'b0,2'd1,4'b0011,4'b0000};
    vecs[11] = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b0, 5'd4,1'b1,2'd2,4'b0011,4'b0000};
    vecs[12] = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b1, 5'd4,1'b0,2'd2,4'b0111,4'b0000};
    vecs[13] = '{1'b0,1'b1,2'd3,5'd5,1'b0,4'b0000,1'b0, 5'd4,1'b0,2'd2,4'b0111,4'b0000};
    vecs[14] = '{1'b1,1'b0,2'd0,5'd0,1'b0,4'b0010,1'b0, 5'd5,1'b0,2'd2,4'b0101,4'b0000};
    vecs[15] = '{1'b1,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b0, 5'd6,1'b0,2'd2,4'b0100,4'b0001};
    vecs[16] = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b0, 5'd6,1'b0,2'd2,4'b0100,4'b0000};
    vecs[17] = '{1'b1,1'b0,2'd0,5'd0,1'b0,4'b0100,1'b0, 5'd7,1'b0,2'd2,4'b0000,4'b0000};
    vecs[18] = '{1'b0,1'b0,2'd0,5'd0,1'b0,4'b0000,1'b0, 5'd7,1'b0,2'd2,4'b0000,4'b0000};

    // Reset values
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_hour",   32'(hour_now),  32'd0);
    chk("rst_req",    32'(disp_req),  32'd0);
    chk("rst_slot",   32'(disp_slot), 32'd0);
    chk("rst_alarm",  32'(alarm),     32'd0);
    chk("rst_missed", 32'(missed),    32'd0);

    // Table: first grant, two-slot round robin, missed dose, taken vs expiry
    for (int r = 0; r < NV; r++) begin
      hour_tick = vecs[r].tick;
      cfg_we    = vecs[r].we;
      cfg_slot  = vecs[r].cslot;
      cfg_hour  = vecs[r].chour;
      cfg_en    = vecs[r].cen;
      taken     = vecs[r].tk;
      disp_ack  = vecs[r].ack;
      step();
      chk($sformatf("v%0d_hour", r),   32'(hour_now),  32'(vecs[r].e_hour));
      chk($sformatf("v%0d_req", r),    32'(disp_req),  32'(vecs[r].e_req));
      chk($sformatf("v%0d_slot", r),   32'(disp_slot), 32'(vecs[r].e_slot));
      chk($sformatf("v%0d_alarm", r),  32'(alarm),     32'(vecs[r].e_alarm));
      chk($sformatf("v%0d_missed", r), 32'(missed),    32'(vecs[r].e_missed));
    end
    hour_tick = 1'b0;
    cfg_we    = 1'b0;
    taken     = 4'd0;
    disp_ack  = 1'b0;

    // Timeout: slots 0 and 3 due at hour 8, rr points at 3; out-of-range write must not disable slot 0
    do_cfg(2'd0, 5'd8, 1'b1);
    do_cfg(2'd3, 5'd8, 1'b1);
    do_cfg(2'd0, 5'd25, 1'b0);
    hour_tick = 1'b1;
    step();
    hour_tick = 1'b0;
    chk("to_hour", 32'(hour_now), 32'd8);
    chk("to_req0", 32'(disp_req), 32'd0);
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("to_hold%0d_req", c),  32'(disp_req),  32'd1);
      chk($sformatf("to_hold%0d_slot", c), 32'(disp_slot), 32'd3);
    end
    step();
    chk("to_gap_req", 32'(disp_req), 32'd0);
    step();
    chk("to_idle_req", 32'(disp_req), 32'd0);
    step();
    chk("other_first_req",  32'(disp_req),  32'd1);
    chk("other_first_slot", 32'(disp_slot), 32'd0);
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    chk("other_ack_req",   32'(disp_req), 32'd0);
    chk("other_ack_alarm", 32'(alarm),    32'b0001);
    step();
    chk("regrant_idle_req", 32'(disp_req), 32'd0);
    step();
    chk("regrant_req",  32'(disp_req),  32'd1);
    chk("regrant_slot", 32'(disp_slot), 32'd3);

    // Reset while a grant is live
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_req",    32'(disp_req),  32'd0);
    chk("midrst_hour",   32'(hour_now),  32'd0);
    chk("midrst_slot",   32'(disp_slot), 32'd0);
    chk("midrst_alarm",  32'(alarm),     32'd0);
    chk("midrst_missed", 32'(missed),    32'd0);

    // Full day with ack held: default schedule grants and hour wrap
    disp_ack = 1'b1;
    for (int k = 0; k < 24; k++) begin
      int  hexp;
      int  hslot;
      logic hit;
      hour_tick = 1'b1;
      step();
      hour_tick = 1'b0;
      hexp  = (k + 1) % 24;
      hit   = 1'b0;
      hslot = 0;
      for (int s = 0; s < 4; s++) begin
        if (sched_ref[s] == hexp) begin
          hit   = 1'b1;
          hslot = s;
        end
      end
      chk($sformatf("day%0d_hour", k), 32'(hour_now), 32'(hexp));
      step();
      chk($sformatf("day%0d_req", k), 32'(disp_req), 32'(hit));
      if (hit) begin
        chk($sformatf("day%0d_slot", k), 32'(disp_slot), 32'(hslot));
      end
      step();
      chk($sformatf("day%0d_gap", k), 32'(disp_req), 32'd0);
    end
    disp_ack = 1'b0;
    chk("wrap_hour", 32'(hour_now), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
